slow_tick_bcd_counter: RTL
==========================

# slow_tick_bcd_counter

Two-digit BCD event counter that consumes the slowed square wave produced by the clock-slowdown stage and advances once per rising edge of that wave. It sits directly downstream of the divider and drives the seven-segment/LED display logic with a stable BCD value. A small run/hold/idle state machine gates the counting. The block also emits single-cycle step and wrap pulses for follow-on logic.

## Interface
Parameters:
- MAX_TENS, 4'd9, tens digit of the terminal count (0–9).
- MAX_ONES, 4'd9, ones digit of the terminal count (0–9).
- The terminal count is MAX_TENS*10+MAX_ONES. It must be ≥1.

Ports:
- clk, input, 1, single system clock; all logic is on posedge.
- rst, input, 1, synchronous, active-high reset.
- slow_in, input, 1, square wave from the slowdown stage, synchronous to clk.
- start, input, 1, level: request RUN.
- stop, input, 1, level: request HOLD.
- clear, input, 1, level: return to IDLE and zero the count.
- dir, input, 1, 1 = count up, 0 = count down; sampled on each step.
- tens, output, 4, BCD tens digit (registered).
- ones, output, 4, BCD ones digit (registered).
- running, output, 1, high while in RUN (registered).
- tick, output, 1, one-cycle pulse; a step was taken.
- wrap, output, 1, one-cycle pulse; the step crossed terminal↔00.

## Operation
- **Edge detection:** prev flop is loaded with slow_in every cycle in every state. rise = slow_in & ~prev.
  - prev resets to 1, so a slow_in that is already high at reset release does not generate a step.
  - An edge that occurs while not in RUN is discarded, not queued.
- **States:** IDLE (2'b00), RUN (2'b01), HOLD (2'b10). 2'b11 is illegal and goes to IDLE on the next clock with the count zeroed.
- **Command priority each cycle:** clear > stop > start.
- **IDLE:**
  - Count is held at 00 and running = 0.
  - start → RUN.
  - stop alone is ignored.
- **RUN:**
  - clear → IDLE, count 00.
  - Else stop → HOLD, count frozen.
  - Else if rise, step.
  - start while in RUN has no effect.
- **HOLD:**
  - clear → IDLE, count 00.
  - Else start → RUN. A rise in the same cycle is not stepped.
  - Else stay in HOLD.
- **Step up:**
  - If count == terminal: count → 00 and wrap = 1.
  - Else if ones == 9: ones → 0, tens + 1.
  - Else ones + 1.
- **Step down:**
  - If count == 00: count → terminal and wrap = 1.
  - Else if ones == 0: ones → 9, tens − 1.
  - Else ones − 1.
- tick = 1 on every step, including wrapping steps.
- Digits never leave 0–9, and the count never exceeds terminal.
- Changing dir between steps is legal and takes effect on the next step.

## Timing
- **Reset** (synchronous, rst sampled high at a posedge):
  - state = IDLE, tens = 0, ones = 0.
  - running = 0, tick = 0, wrap = 0, prev = 1.
  - rst overrides every other input, including mid-RUN.
- **Step latency:** slow_in low at posedge k−1 and high at posedge k gives new tens/ones, tick and wrap all valid after posedge k. That is one clock from sampling.
- tick and wrap are high for exactly one cycle and are 0 in every cycle without a step.
- **Max step rate:** one step per two clocks, since rise needs a low sample then a high sample. Back-to-back toggling slow_in (period 2) must step on every rising sample.
- **State changes:** running changes in the same cycle as the state register. For example, start sampled at posedge k gives running = 1 after posedge k.
- **Clear/stop vs. edge:** clear or stop sampled together with a rise suppresses the step. No tick or wrap is generated.

## Test plan
- **Reset then run:** rst for 2 cycles, hold slow_in = 1, pulse start.
  - Expect tens/ones = 0/0, running = 1 and no tick until slow_in goes low then high.
  - The first rise gives 0/1 with tick = 1 for one cycle.
- **Up wrap** (default 99): count up through 5 rises from 9/7.
  - Expect 9/8, 9/9, 0/0 (wrap = 1 and tick = 1 on that cycle only), 0/1, 0/2.
  - Expect 0/9 → 1/0 carry when the counter passes 09.
- **Down wrap** with MAX_TENS = 0, MAX_ONES = 5: dir = 0 from 0/1, 3 rises.
  - Expect 0/0, 0/5 (wrap = 1), 0/4.
- **Hold and priority:** at count 4/2 in RUN, assert stop together with a rise.
  - Expect HOLD, count stays 4/2, running = 0, no tick.
  - Further rises: no change.
  - start + clear in the same cycle: expect IDLE with 0/0.
- **Discarded edges:** in IDLE, toggle slow_in 3 times, then assert start with slow_in already high.
  - Expect count 0/0 until the next genuine low→high.
- **Reset mid-operation:** at count 3/7 in RUN with a rise coincident with rst.
  - Expect 0/0, IDLE, running = 0, tick = 0, wrap = 0 after that posedge.

Source files
------------

// File: rtl/slow_tick_bcd_counter_if.sv
// slow_tick_bcd_counter_if: control inputs and BCD display outputs of the slow-tick counter.
interface slow_tick_bcd_counter_if;
  logic       slow_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic       dir;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       tick;
  logic       wrap;
  modport master (
    output slow_in, start, stop, clear, dir,
    input  tens, ones, running, tick, wrap
  );
  modport slave (
    input  slow_in, start, stop, clear, dir,
    output tens, ones, running, tick, wrap
  );
endinterface

// File: rtl/slow_tick_bcd_counter.sv
// slow_tick_bcd_counter: two-digit BCD up/down counter stepped by rising edges of a slowed clock.
module slow_tick_bcd_counter #(
  parameter logic [3:0] MAX_TENS = 4'd9,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input logic              clk,
  input logic              rst,
  slow_tick_bcd_counter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10;
  logic [1:0] r_state, w_next;
  logic [3:0] r_tens, r_ones, w_tens, w_ones;
  logic       r_prev, r_tick, r_wrap, r_running;
  logic       w_rise, w_step, w_wrap, w_at_term, w_at_zero;
  assign w_rise = bus.slow_in & ~r_prev;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // In IDLE a stop outranks start, and stop alone does nothing there.
  always_comb begin
    w_next = (r_state == RUN)  ? (bus.clear ? IDLE : bus.stop ? HOLD : RUN) :
             (r_state == HOLD) ? (bus.clear ? IDLE : bus.start ? RUN : HOLD) :
             (r_state == IDLE) ? ((!bus.clear && !bus.stop && bus.start) ? RUN : IDLE) :
             IDLE;
  end
  // A step only happens when RUN persists, so clear/stop swallow a coincident rise.
  always_comb begin
    w_step    = (r_state == RUN) && (w_next == RUN) && w_rise;
    w_at_term = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    w_wrap    = w_step && (bus.dir ? w_at_term : w_at_zero);
    w_tens    = (w_next == IDLE) ? 4'd0 :
                w_wrap ? (bus.dir ? 4'd0 : MAX_TENS) :
                !w_step ? r_tens :
                bus.dir ? ((r_ones == 4'd9) ? r_tens + 4'd1 : r_tens) :
                ((r_ones == 4'd0) ? r_tens - 4'd1 : r_tens);
    w_ones    = (w_next == IDLE) ? 4'd0 :
                w_wrap ? (bus.dir ? 4'd0 : MAX_ONES) :
                !w_step ? r_ones :
                bus.dir ? ((r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1) :
                ((r_ones == 4'd0) ? 4'd9 : r_ones - 4'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= 1'b1;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_prev    <= bus.slow_in;
      r_tens    <= w_tens;
      r_ones    <= w_ones;
      r_tick    <= w_step;
      r_wrap    <= w_wrap;
      r_running <= (w_next == RUN);
    end
  end
  assign bus.tens    = r_tens;
  assign bus.ones    = r_ones;
  assign bus.running = r_running;
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;
endmodule
